fp_square: RTL
==============

# fp_square

Iterative single-precision floating-point squaring unit (result = in_data × in_data), the inverse operation of the FP square-root unit in the FP_Unit datapath. It uses the same start/stall handshake so the FP_Unit controller can drive both blocks identically. The 24×24 mantissa product is formed by a sequential shift-add multiplier. Normalization, round-to-nearest-even and special-value handling take one extra cycle.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 (IEEE-754 binary32) is supported.
- in_Clk  input  1  clock; all state updates on the rising edge.
- in_Rst_N  input  1  reset, synchronous and active-low.
- in_start  input  1  request; accepted only when out_stall is 0.
- in_data  input  DATA_WIDTH  operand; sampled only on the accepting edge.
- out_data  output  DATA_WIDTH  result; holds the last completed result until the next completion.
- out_stall  output  1  busy; 1 from the accept edge until the result is written.

## Operation
- States:
  - IDLE: if in_start=1, capture sign/exponent/mantissa, set cnt=0, go to MUL.
  - MUL: 24 iterations, then go to NORM.
  - NORM: write out_data, return to IDLE.
- Operand capture:
  - E = in_data[30:23].
  - M = {1, in_data[22:0]} (24 bits).
  - Multiplicand register = M zero-extended to 48 bits.
  - Multiplier register = M.
  - Accumulator P = 0.
- MUL iteration, each cycle:
  - If multiplier[0]=1, P += multiplicand.
  - Shift multiplicand left 1 and multiplier right 1.
  - cnt++.
  - After iteration cnt=23, P holds M², which lies in [2^46, 2^48).
- NORM, normalization:
  - If P[47]=1: frac = P[46:24], guard = P[23], sticky = |P[22:0], exp = 2E−127+1.
  - Otherwise: frac = P[45:23], guard = P[22], sticky = |P[21:0], exp = 2E−127.
  - Compute exp in signed 10-bit arithmetic.
- NORM, rounding (RNE):
  - Increment frac if guard & (sticky | frac[0]).
  - If frac carries out, frac = 0 and exp += 1.
- Result priority, highest first:
  1. E=255 with nonzero fraction (NaN) → 0x7FC00000, the canonical qNaN.
  2. E=255 with zero fraction (±Inf) → 0x7F800000.
  3. E=0 (zero or denormal input; flush-to-zero) → 0x00000000.
  4. Final exp ≥ 255 → 0x7F800000.
  5. Final exp ≤ 0 → 0x00000000; denormal results are flushed.
  6. Otherwise → {0, exp[7:0], frac}.
- Result sign is always 0.
- Special values still traverse MUL, so latency is fixed regardless of operand.

## Timing
- Reset (in_Rst_N=0 at an edge): state=IDLE, out_stall=0, out_data=0x00000000, cnt=0, P=0.
  - Reset mid-operation aborts the operation.
  - No result is written.
- Handshake:
  - Request accepted at edge k (in_start=1, out_stall=0).
  - out_stall=1 after edge k.
  - MUL iterations run at edges k+1 … k+24.
  - NORM completes at edge k+25: out_data is updated and out_stall=0.
- Latency: 25 cycles from accept edge to result; out_stall is high for exactly 25 cycles.
- in_start while out_stall=1 is ignored. No queuing, and in_data changes have no effect.
- Back-to-back: in_start=1 in the first cycle with out_stall=0 is accepted at the next edge. Peak throughput is one result per 26 cycles.
- in_start held high continuously gives repeated operations, each sampling in_data at its own accept edge.
- out_data changes only at a NORM edge or at reset.

## Test plan
- Basic squares: 0x40400000 (3.0) → 0x41100000 (9.0); 0x3FC00000 (1.5) → 0x40100000 (2.25). out_stall is high for exactly 25 cycles, and out_data is unchanged until edge k+25.
- Sign and rounding:
  - 0xC0000000 (−2.0) → 0x40800000.
  - 0x3F800001 → 0x3F800002, where the discarded bits are below half so the result rounds down.
  - 0x3FB504F3 → 0x3FFFFFFF.
- Specials:
  - 0x7FC00001 → 0x7FC00000.
  - 0xFF800000 → 0x7F800000.
  - 0x80000000 → 0x00000000.
  - Denormal 0x00000001 → 0x00000000.
- Range limits: 0x7F000000 (2^127) → 0x7F800000 overflow; 0x1F800000 (2^−64) → 0x00000000 underflow flush.
- Handshake:
  - in_start pulsed with a different in_data at cycles k+5 and k+24 is ignored; the result belongs to the first operand.
  - in_start held high over two operations gives two results 26 cycles apart.
- Reset: assert in_Rst_N=0 at cycle k+10 of an operation → next cycle out_stall=0 and out_data=0x00000000. A new request then completes normally after 25 cycles.

Source files
------------

// File: rtl/fp_square.sv
// Iterative binary32 squaring unit: shift-add 24x24 mantissa product over 24 cycles,
// then one cycle of normalize, round-to-nearest-even and special-value selection.

module fp_square_round (
  input  logic        sign,
  input  logic [7:0]  e,
  input  logic        frac_nz,
  input  logic [47:0] p,
  output logic [31:0] res
);
  logic              top;
  logic [22:0]       frac;
  logic              guard;
  logic              sticky;
  logic              rnd;
  logic [23:0]       frac_r;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_f;

  assign top = p[47];

  always_comb begin
    frac   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    if (top) begin
      frac   = p[46:24];
      guard  = p[23];
      sticky = |p[22:0];
    end else begin
      frac   = p[45:23];
      guard  = p[22];
      sticky = |p[21:0];
    end
    // 2E - bias, plus one when the product spilled into bit 47
    exp_n  = $signed({1'b0, e, 1'b0}) - 10'sd127 + $signed({9'd0, top});
    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {23'd0, rnd};
    exp_f  = frac_r[23] ? exp_n + 10'sd1 : exp_n;
  end

  always_comb begin
    res = '0;
    if (e == 8'hFF && frac_nz)
      res = 32'h7FC0_0000;
    else if (e == 8'hFF)
      res = 32'h7F80_0000;
    else if (e == 8'h00)
      res = 32'h0000_0000;
    else if (exp_f >= 10'sd255)
      res = 32'h7F80_0000;
    else if (exp_f <= 10'sd0)
      res = 32'h0000_0000;
    else
      // product sign is s^s, which is always 0 for a square
      res = {sign ^ sign, exp_f[7:0], frac_r[22:0]};
  end
endmodule

module fp_square #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_start,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_stall
);
  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic       frac_nz;
  } op_t;

  state_t      state;
  op_t         op;
  logic [4:0]  cnt;
  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [47:0] p;
  logic [31:0] res;

  fp_square_round u_round (
    .sign    (op.s),
    .e       (op.e),
    .frac_nz (op.frac_nz),
    .p       (p),
    .res     (res)
  );

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_N) begin
      state     <= IDLE;
      op        <= '0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      p         <= '0;
      out_data  <= '0;
      out_stall <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            op.s       <= in_data[31];
            op.e       <= in_data[30:23];
            op.frac_nz <= |in_data[22:0];
            mcand      <= {24'd0, 1'b1, in_data[22:0]};
            mplier     <= {1'b1, in_data[22:0]};
            p          <= '0;
            cnt        <= '0;
            out_stall  <= 1'b1;
            state      <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) p <= p + mcand;
          mcand  <= {mcand[46:0], 1'b0};
          mplier <= {1'b0, mplier[23:1]};
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd23) state <= NORM;
        end
        NORM: begin
          out_data  <= res;
          out_stall <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
